// File: rtl/m_div_control.sv
// ---------------------------------------------------------------------------
// m_div_control
//
// Sequencing controller for the M-unit's iterative restoring divider.
// It accepts a DIV/DIVU/REM/REMU request and steers the m_registers datapath
// through one load cycle and 32 shift-subtract cycles. It then applies RISC-V
// sign correction and presents a registered result with a one-cycle valid
// pulse.
//
// Divide-by-zero and signed overflow (0x80000000 / -1) are answered directly
// from IDLE. The datapath is not touched in those cases.
//
// Ports
//   clk          clock
//   resetn       asynchronous, active-low reset
//   start_i      request strobe, sampled only in IDLE
//   op_i[1:0]    00 DIV, 01 DIVU, 10 REM, 11 REMU (sampled with start_i)
//   rs1_i[31:0]  dividend (valid in the start_i cycle)
//   rs2_i[31:0]  divisor  (valid in the start_i cycle)
//   sub_neg_i    sign of datapath R-D; consumed by the datapath only
//   R_i[31:0]    datapath remainder register
//   Z_i[31:0]    datapath quotient register
//   mux_R_o      remainder select (MUX_R_* encodings below)
//   mux_D_o      divisor select   (MUX_D_* encodings below)
//   mux_Z_o      quotient select  (MUX_Z_* encodings below)
//   busy_o       high whenever the FSM is not in IDLE
//   valid_o      one-cycle pulse marking result_o as new
//   result_o     registered result, held until the next valid_o
//   state_o      current FSM state (00 IDLE, 01 ITER, 10 FIN) for debug
//
// Handshake: start_i is a single-cycle request. It is taken only while
// busy_o is low and is otherwise dropped, never queued. valid_o is a pulse
// with no back-pressure. A new start_i may be given in the valid_o cycle.
// ---------------------------------------------------------------------------
module m_div_control (
    input  logic        clk,
    input  logic        resetn,
    input  logic        start_i,
    input  logic [1:0]  op_i,
    input  logic [31:0] rs1_i,
    input  logic [31:0] rs2_i,
    input  logic        sub_neg_i,
    input  logic [31:0] R_i,
    input  logic [31:0] Z_i,
    output logic [1:0]  mux_R_o,
    output logic [1:0]  mux_D_o,
    output logic [1:0]  mux_Z_o,
    output logic        busy_o,
    output logic        valid_o,
    output logic [31:0] result_o,
    output logic [1:0]  state_o
);

    // Datapath select encodings, shared with m_registers.
    localparam logic [1:0] MUX_R_KEEP     = 2'd0;
    localparam logic [1:0] MUX_R_A        = 2'd1;
    localparam logic [1:0] MUX_R_A_NEG    = 2'd2;
    localparam logic [1:0] MUX_R_SUB_KEEP = 2'd3;

    localparam logic [1:0] MUX_D_KEEP     = 2'd0;
    localparam logic [1:0] MUX_D_B        = 2'd1;
    localparam logic [1:0] MUX_D_B_NEG    = 2'd2;
    localparam logic [1:0] MUX_D_SHR      = 2'd3;

    localparam logic [1:0] MUX_Z_KEEP     = 2'd0;
    localparam logic [1:0] MUX_Z_ZERO     = 2'd1;
    localparam logic [1:0] MUX_Z_SHL_ADD  = 2'd2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ITER = 2'd1,
        FIN  = 2'd2
    } state_t;

    state_t      r_state;
    logic [4:0]  r_cnt;
    logic        r_is_rem;
    logic        r_neg_q;
    logic        r_neg_r;
    logic        r_valid;
    logic [31:0] r_result;

    // The keep/accept decision lives in the datapath, so the controller
    // sequences identically regardless of data.
    logic w_unused;
    assign w_unused = sub_neg_i;

    logic        w_signed;
    logic        w_is_rem;
    logic        w_div0;
    logic        w_ovf;
    logic        w_special;
    logic        w_neg_q;
    logic        w_neg_r;
    logic [31:0] w_special_result;
    logic [31:0] w_fin_result;

    assign w_signed  = ~op_i[0];
    assign w_is_rem  = op_i[1];
    assign w_div0    = (rs2_i == 32'd0);
    assign w_ovf     = w_signed && (rs1_i == 32'h8000_0000) && (rs2_i == 32'hFFFF_FFFF);
    assign w_special = w_div0 | w_ovf;
    assign w_neg_q   = w_signed & (rs1_i[31] ^ rs2_i[31]);
    assign w_neg_r   = w_signed & rs1_i[31];

    // Divide-by-zero takes priority over overflow.
    always_comb begin
        w_special_result = 32'd0;
        if (w_div0) begin
            w_special_result = w_is_rem ? rs1_i : 32'hFFFF_FFFF;
        end else begin
            w_special_result = w_is_rem ? 32'd0 : 32'h8000_0000;
        end
    end

    // Two's-complement negation mod 2^32. A magnitude of 0x80000000 maps to
    // itself, which is the correct signed result.
    always_comb begin
        w_fin_result = 32'd0;
        if (r_is_rem) begin
            w_fin_result = r_neg_r ? (~R_i + 32'd1) : R_i;
        end else begin
            w_fin_result = r_neg_q ? (~Z_i + 32'd1) : Z_i;
        end
    end

    // The selects are combinational, so the datapath load happens on the
    // same edge that moves the FSM from IDLE to ITER.
    always_comb begin
        mux_R_o = MUX_R_KEEP;
        mux_D_o = MUX_D_KEEP;
        mux_Z_o = MUX_Z_KEEP;
        case (r_state)
            IDLE: begin
                if (start_i && !w_special) begin
                    mux_R_o = w_neg_r ? MUX_R_A_NEG : MUX_R_A;
                    mux_D_o = (w_signed && rs2_i[31]) ? MUX_D_B_NEG : MUX_D_B;
                    mux_Z_o = MUX_Z_ZERO;
                end
            end
            ITER: begin
                mux_R_o = MUX_R_SUB_KEEP;
                mux_D_o = MUX_D_SHR;
                mux_Z_o = MUX_Z_SHL_ADD;
            end
            default: begin
                mux_R_o = MUX_R_KEEP;
                mux_D_o = MUX_D_KEEP;
                mux_Z_o = MUX_Z_KEEP;
            end
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state  <= IDLE;
            r_cnt    <= 5'd0;
            r_is_rem <= 1'b0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_valid  <= 1'b0;
            r_result <= 32'd0;
        end else begin
            r_valid <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start_i) begin
                        if (w_special) begin
                            r_result <= w_special_result;
                            r_valid  <= 1'b1;
                        end else begin
                            r_is_rem <= w_is_rem;
                            r_neg_q  <= w_neg_q;
                            r_neg_r  <= w_neg_r;
                            r_cnt    <= 5'd0;
                            r_state  <= ITER;
                        end
                    end
                end
                ITER: begin
                    // 32 iterations: cnt runs 0..31 and wraps back to 0.
                    r_cnt <= r_cnt + 5'd1;
                    if (r_cnt == 5'd31) begin
                        r_state <= FIN;
                    end
                end
                FIN: begin
                    r_result <= w_fin_result;
                    r_valid  <= 1'b1;
                    r_state  <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign busy_o   = (r_state != IDLE);
    assign valid_o  = r_valid;
    assign result_o = r_result;
    assign state_o  = r_state;

endmodule

// File: tb/tb_m_div_control.sv
// ---------------------------------------------------------------------------
// tb_m_div_control
//
// Directed bench for m_div_control. The datapath is not instantiated.
// R_i and Z_i are driven with the hand-computed unsigned magnitudes that
// m_registers would hold after 32 iterations. This isolates the controller's
// sequencing, special cases and sign correction. Expected results are queued
// when each request is issued and popped when valid_o pulses.
// ---------------------------------------------------------------------------
module tb_m_div_control;

    localparam logic [1:0] OP_DIV  = 2'b00;
    localparam logic [1:0] OP_DIVU = 2'b01;
    localparam logic [1:0] OP_REM  = 2'b10;
    localparam logic [1:0] OP_REMU = 2'b11;

    // Select encodings expected at the ports.
    localparam logic [1:0] R_KEEP = 2'd0, R_A = 2'd1, R_A_NEG = 2'd2, R_SUB_KEEP = 2'd3;
    localparam logic [1:0] D_KEEP = 2'd0, D_B = 2'd1, D_B_NEG = 2'd2, D_SHR = 2'd3;
    localparam logic [1:0] Z_KEEP = 2'd0, Z_ZERO = 2'd1, Z_SHL_ADD = 2'd2;

    localparam logic [1:0] ST_IDLE = 2'd0, ST_ITER = 2'd1, ST_FIN = 2'd2;

    // ---------------- clock / reset ----------------
    logic        clk;
    logic        resetn;
    logic        start_i;
    logic [1:0]  op_i;
    logic [31:0] rs1_i;
    logic [31:0] rs2_i;
    logic        sub_neg_i;
    logic [31:0] R_i;
    logic [31:0] Z_i;
    logic [1:0]  mux_R_o;
    logic [1:0]  mux_D_o;
    logic [1:0]  mux_Z_o;
    logic        busy_o;
    logic        valid_o;
    logic [31:0] result_o;
    logic [1:0]  state_o;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    m_div_control dut (
        .clk       (clk),
        .resetn    (resetn),
        .start_i   (start_i),
        .op_i      (op_i),
        .rs1_i     (rs1_i),
        .rs2_i     (rs2_i),
        .sub_neg_i (sub_neg_i),
        .R_i       (R_i),
        .Z_i       (Z_i),
        .mux_R_o   (mux_R_o),
        .mux_D_o   (mux_D_o),
        .mux_Z_o   (mux_Z_o),
        .busy_o    (busy_o),
        .valid_o   (valid_o),
        .result_o  (result_o),
        .state_o   (state_o)
    );

    // ---------------- scoreboard ----------------
    logic [31:0] exp_q[$];
    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    // ---------------- driver tasks ----------------
    // Advance one clock; afterwards we sit 1ns past the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issue one request in the current cycle (cycle 0) and follow it to
    // completion. For a normal op, er/ed/ez are the expected load selects.
    // A non-zero inject gives a stray DIV 9/3 start in that busy cycle.
    task automatic run_op(input string tag, input logic [1:0] op,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] rmag, input logic [31:0] zmag,
                          input logic [31:0] expv, input logic special,
                          input logic [1:0] er, input logic [1:0] ed,
                          input logic [1:0] ez, input int inject);
        int cyc;
        int busy_cnt;
        logic [31:0] want;
        op_i    = op;
        rs1_i   = a;
        rs2_i   = b;
        R_i     = rmag;
        Z_i     = zmag;
        sub_neg_i = 1'($urandom_range(0, 1));
        start_i = 1'b1;
        #1;
        chk({tag, "_load_R"}, mux_R_o, er);
        chk({tag, "_load_D"}, mux_D_o, ed);
        chk({tag, "_load_Z"}, mux_Z_o, ez);
        exp_q.push_back(expv);
        step();
        start_i  = 1'b0;
        cyc      = 1;
        busy_cnt = 0;
        while (valid_o !== 1'b1 && cyc < 60) begin
            if (busy_o === 1'b1) busy_cnt++;
            if (cyc == 1) begin
                chk({tag, "_iter_R"}, mux_R_o, R_SUB_KEEP);
                chk({tag, "_iter_D"}, mux_D_o, D_SHR);
                chk({tag, "_iter_Z"}, mux_Z_o, Z_SHL_ADD);
            end
            if (cyc == 33) begin
                chk({tag, "_fin_state"}, state_o, ST_FIN);
                chk({tag, "_fin_sel"}, {mux_R_o, mux_D_o, mux_Z_o}, 6'd0);
            end
            if (inject != 0 && cyc == inject) begin
                start_i = 1'b1;
                op_i    = OP_DIV;
                rs1_i   = 32'd9;
                rs2_i   = 32'd3;
            end else begin
                start_i = 1'b0;
            end
            step();
            cyc++;
        end
        start_i = 1'b0;
        chk({tag, "_latency"}, cyc, special ? 32'd1 : 32'd34);
        chk({tag, "_busy_cycles"}, busy_cnt, special ? 32'd0 : 32'd33);
        if (exp_q.size() > 0) begin
            want = exp_q.pop_front();
            chk({tag, "_result"}, result_o, want);
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int vcnt;
        resetn    = 1'b0;
        start_i   = 1'b0;
        op_i      = 2'b00;
        rs1_i     = 32'd0;
        rs2_i     = 32'd0;
        sub_neg_i = 1'b0;
        R_i       = 32'd0;
        Z_i       = 32'd0;

        #2;
        chk("rst_busy", busy_o, 1'b0);
        chk("rst_valid", valid_o, 1'b0);
        chk("rst_result", result_o, 32'd0);
        chk("rst_sel", {mux_R_o, mux_D_o, mux_Z_o}, 6'd0);
        chk("rst_state", state_o, ST_IDLE);
        step();
        step();
        resetn = 1'b1;
        step();
        chk("idle_sel", {mux_R_o, mux_D_o, mux_Z_o}, 6'd0);

        // Basic unsigned-magnitude cases.
        run_op("div_100_7", OP_DIV, 32'd100, 32'd7, 32'd2, 32'd14, 32'd14, 1'b0, R_A, D_B, Z_ZERO, 0);
        step();
        chk("valid_drop", valid_o, 1'b0);
        chk("result_hold", result_o, 32'd14);
        run_op("rem_100_7", OP_REM, 32'd100, 32'd7, 32'd2, 32'd14, 32'd2, 1'b0, R_A, D_B, Z_ZERO, 0);

        // Signed correction: magnitudes 7/2 give Z=3, R=1.
        step();
        run_op("div_m7_2", OP_DIV, 32'hFFFF_FFF9, 32'd2, 32'd1, 32'd3, 32'hFFFF_FFFD, 1'b0, R_A_NEG, D_B, Z_ZERO, 0);
        run_op("rem_m7_2", OP_REM, 32'hFFFF_FFF9, 32'd2, 32'd1, 32'd3, 32'hFFFF_FFFF, 1'b0, R_A_NEG, D_B, Z_ZERO, 0);
        run_op("div_7_m2", OP_DIV, 32'd7, 32'hFFFF_FFFE, 32'd1, 32'd3, 32'hFFFF_FFFD, 1'b0, R_A, D_B_NEG, Z_ZERO, 0);
        run_op("rem_7_m2", OP_REM, 32'd7, 32'hFFFF_FFFE, 32'd1, 32'd3, 32'd1, 1'b0, R_A, D_B_NEG, Z_ZERO, 0);

        // Unsigned ops never negate, even with bit 31 set.
        run_op("divu_ff_1", OP_DIVU, 32'hFFFF_FFFF, 32'd1, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, R_A, D_B, Z_ZERO, 0);
        run_op("remu_ff_10", OP_REMU, 32'hFFFF_FFFF, 32'h10, 32'hF, 32'h0FFF_FFFF, 32'hF, 1'b0, R_A, D_B, Z_ZERO, 0);
        run_op("divu_8m_2", OP_DIVU, 32'h8000_0000, 32'd2, 32'd0, 32'h4000_0000, 32'h4000_0000, 1'b0, R_A, D_B, Z_ZERO, 0);

        // Special cases answered from IDLE, back-to-back.
        step();
        run_op("div_5_0", OP_DIV, 32'd5, 32'd0, 32'd0, 32'd0, 32'hFFFF_FFFF, 1'b1, R_KEEP, D_KEEP, Z_KEEP, 0);
        run_op("remu_5_0", OP_REMU, 32'd5, 32'd0, 32'd0, 32'd0, 32'd5, 1'b1, R_KEEP, D_KEEP, Z_KEEP, 0);
        run_op("div_ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'd0, 32'h8000_0000, 1'b1, R_KEEP, D_KEEP, Z_KEEP, 0);
        run_op("rem_ovf", OP_REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'd0, 32'd0, 1'b1, R_KEEP, D_KEEP, Z_KEEP, 0);

        // Stray start during ITER is ignored; the next start, issued in the
        // valid_o cycle, is accepted.
        step();
        run_op("div_ignore", OP_DIV, 32'd100, 32'd7, 32'd2, 32'd14, 32'd14, 1'b0, R_A, D_B, Z_ZERO, 10);
        run_op("b2b_rem", OP_REM, 32'd100, 32'd7, 32'd2, 32'd14, 32'd2, 1'b0, R_A, D_B, Z_ZERO, 0);
        vcnt = 0;
        for (int i = 0; i < 5; i++) begin
            step();
            if (valid_o === 1'b1) vcnt++;
        end
        chk("no_extra_valid", vcnt, 32'd0);
        chk("idle_after", busy_o, 1'b0);

        // Reset in ITER cycle 15.
        op_i    = OP_DIV;
        rs1_i   = 32'd100;
        rs2_i   = 32'd7;
        R_i     = 32'd2;
        Z_i     = 32'd14;
        start_i = 1'b1;
        step();
        start_i = 1'b0;
        repeat (14) step();
        chk("mid_state", state_o, ST_ITER);
        resetn = 1'b0;
        #1;
        chk("mid_rst_busy", busy_o, 1'b0);
        chk("mid_rst_valid", valid_o, 1'b0);
        chk("mid_rst_result", result_o, 32'd0);
        chk("mid_rst_sel", {mux_R_o, mux_D_o, mux_Z_o}, 6'd0);
        step();
        resetn = 1'b1;
        vcnt = 0;
        for (int i = 0; i < 40; i++) begin
            step();
            if (valid_o === 1'b1) vcnt++;
        end
        chk("abort_no_valid", vcnt, 32'd0);
        run_op("div_after_rst", OP_DIV, 32'd100, 32'd7, 32'd2, 32'd14, 32'd14, 1'b0, R_A, D_B, Z_ZERO, 0);

        chk("queue_empty", exp_q.size(), 32'd0);

        // ---------------- final report ----------------
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
